// File: rtl/mem_read_unit.sv
// -----------------------------------------------------------------------------
// mem_read_unit
//   Issues a single-word read to a memory with a ready/valid style acknowledge.
//   A read is accepted in IDLE, the address is latched and held for the whole
//   request, and the FSM waits up to TIMEOUT cycles in REQ for mem_ready.
//   Completion is flagged with a one-cycle done pulse; a timeout is flagged
//   with a one-cycle error pulse. DataOut keeps the last successfully read word.
//
// Ports
//   clock      : single clock, all state updates on the rising edge
//   clear      : synchronous active-low reset
//   rd_start   : read request, sampled only in IDLE
//   rd_addr    : read address, sampled together with rd_start
//   busy       : high whenever the FSM is not in IDLE
//   done       : one-cycle pulse on successful completion
//   error      : one-cycle pulse on timeout
//   DataOut    : last successfully read word
//   mem_addr   : latched read address presented to memory
//   mem_read   : read strobe to memory, high only in REQ
//   mem_ready  : memory data-valid acknowledge
//   mem_data   : memory read data, valid while mem_ready is high
// -----------------------------------------------------------------------------
module mem_read_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15   // 1..255
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] DataOut,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  // Counter value at which an unanswered REQ cycle turns into a timeout.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   data_q,  data_d;
  logic [7:0]          cnt_q,   cnt_d;

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: every register here is an ordinary flop (no memory array), so all
    // of them are cleared; clear wins over any pending transition.
    if (!clear) begin
      // NOTE: non-blocking assignments keep every flop sampling the
      // pre-edge values, so ordering inside this block does not matter.
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal; otherwise
    // synthesis would infer latches to hold the missing cases.
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (rd_start) begin
          addr_d  = rd_addr;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // mem_ready is checked first so a late acknowledge on the final
        // allowed cycle still completes instead of timing out.
        if (mem_ready) begin
          data_d  = mem_data;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: pure decodes of the registered state, so done and error are
  // glitch-free and mutually exclusive by construction.
  always_comb begin
    busy     = (state_q != IDLE);
    mem_read = (state_q == REQ);
    done     = (state_q == DONE);
    error    = (state_q == ERR);
    mem_addr = addr_q;
    DataOut  = data_q;
  end

endmodule

// File: tb/tb_mem_read_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_read_unit
//   Directed self-checking bench for mem_read_unit (default parameters).
//   Inputs change 1 ns after each rising edge; outputs are checked at the
//   same point, i.e. they show the state produced by the preceding edge.
// -----------------------------------------------------------------------------
module tb_mem_read_unit;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 15;

  logic              clock = 1'b0;
  logic              clear;
  logic              rd_start;
  logic [ADDR_W-1:0] rd_addr;
  logic              busy;
  logic              done;
  logic              error;
  logic [DATA_W-1:0] DataOut;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_data;

  int errors = 0;
  int checks = 0;

  mem_read_unit #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .rd_start (rd_start),
    .rd_addr  (rd_addr),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .DataOut  (DataOut),
    .mem_addr (mem_addr),
    .mem_read (mem_read),
    .mem_ready(mem_ready),
    .mem_data (mem_data)
  );

  always #5 clock = ~clock;

  // Hard time limit so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One rising edge, then settle 1 ns past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int rd_cycles;
    int guard;
    logic done_seen;

    clear     = 1'b0;
    rd_start  = 1'b0;
    rd_addr   = '0;
    mem_ready = 1'b0;
    mem_data  = '0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_busy",     busy,     0);
    check("rst_mem_read", mem_read, 0);
    check("rst_done",     done,     0);
    check("rst_error",    error,    0);
    check("rst_dataout",  DataOut,  0);
    check("rst_mem_addr", mem_addr, 0);
    clear = 1'b1;
    tick();

    // ---------------- mem_ready ignored in IDLE ----------------
    mem_ready = 1'b1;
    mem_data  = 32'hFFFF_FFFF;
    tick();
    check("idle_ign_busy",    busy,    0);
    check("idle_ign_dataout", DataOut, 0);
    mem_ready = 1'b0;
    mem_data  = '0;

    // ---------------- basic read ----------------
    rd_start = 1'b1;
    rd_addr  = 9'h012;
    tick();                                   // edge 0: IDLE -> REQ
    check("basic_req_busy",     busy,     1);
    check("basic_req_mem_read", mem_read, 1);
    check("basic_req_mem_addr", mem_addr, 32'h012);
    check("basic_req_done",     done,     0);
    rd_start  = 1'b0;
    mem_ready = 1'b1;
    mem_data  = 32'h0000_0012;
    tick();                                   // edge 1: REQ -> DONE
    check("basic_done",         done,     1);
    check("basic_dataout",      DataOut,  32'h0000_0012);
    check("basic_done_mem_read",mem_read, 0);
    check("basic_done_error",   error,    0);
    mem_ready = 1'b0;
    mem_data  = '0;
    tick();                                   // DONE -> IDLE
    check("basic_idle_busy", busy, 0);
    check("basic_idle_done", done, 0);

    // ---------------- wait states ----------------
    rd_start = 1'b1;
    rd_addr  = 9'h0A5;
    tick();
    rd_start  = 1'b0;
    rd_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_read) rd_cycles++;
      if (error) check("wait_error_low", error, 0);
      tick();
    end
    check("wait_dataout_held", DataOut, 32'h0000_0012);
    if (mem_read) rd_cycles++;
    mem_ready = 1'b1;
    mem_data  = 32'hDEAD_BEEF;
    tick();
    check("wait_rd_cycles", rd_cycles, 6);
    check("wait_done",      done,      1);
    check("wait_error",     error,     0);
    check("wait_dataout",   DataOut,   32'hDEAD_BEEF);
    mem_ready = 1'b0;
    mem_data  = '0;
    tick();

    // ---------------- timeout ----------------
    rd_start = 1'b1;
    rd_addr  = 9'h100;
    tick();
    rd_start  = 1'b0;
    rd_cycles = 0;
    guard     = 0;
    done_seen = 1'b0;
    while (!error && guard < 40) begin
      if (mem_read) rd_cycles++;
      if (done) done_seen = 1'b1;
      tick();
      guard++;
    end
    check("to_error",     error,     1);
    check("to_rd_cycles", rd_cycles, TIMEOUT);
    check("to_done_seen", done_seen, 0);
    check("to_done",      done,      0);
    check("to_dataout",   DataOut,   32'hDEAD_BEEF);
    check("to_mem_read",  mem_read,  0);
    tick();
    check("to_error_pulse", error, 0);
    check("to_idle_busy",   busy,  0);

    // ---------------- timeout boundary ----------------
    rd_start = 1'b1;
    rd_addr  = 9'h0F0;
    tick();                                   // REQ cycle 1
    rd_start = 1'b0;
    repeat (TIMEOUT - 1) tick();              // now in REQ cycle 15
    check("bnd_mem_read", mem_read, 1);
    check("bnd_pre_error", error,   0);
    mem_ready = 1'b1;
    mem_data  = 32'h0000_0001;
    tick();
    check("bnd_done",    done,    1);
    check("bnd_error",   error,   0);
    check("bnd_dataout", DataOut, 32'h0000_0001);
    mem_ready = 1'b0;
    mem_data  = '0;
    tick();
    check("bnd_idle_error", error, 0);

    // ---------------- reset mid-read ----------------
    rd_start = 1'b1;
    rd_addr  = 9'h077;
    tick();                                   // REQ cycle 1
    rd_start = 1'b0;
    tick();                                   // REQ cycle 2
    tick();                                   // REQ cycle 3
    check("rmr_in_req", mem_read, 1);
    clear = 1'b0;
    mem_ready = 1'b1;                         // reset must win over ready
    mem_data  = 32'h1234_5678;
    tick();
    check("rmr_busy",     busy,     0);
    check("rmr_mem_read", mem_read, 0);
    check("rmr_dataout",  DataOut,  0);
    check("rmr_mem_addr", mem_addr, 0);
    check("rmr_done",     done,     0);
    check("rmr_error",    error,    0);
    clear     = 1'b1;
    mem_ready = 1'b0;
    mem_data  = '0;
    tick();
    check("rmr_post_done",  done,  0);
    check("rmr_post_error", error, 0);
    rd_start = 1'b1;
    rd_addr  = 9'h033;
    tick();
    rd_start  = 1'b0;
    mem_ready = 1'b1;
    mem_data  = 32'h5A5A_A5A5;
    tick();
    check("rmr_again_done",    done,    1);
    check("rmr_again_dataout", DataOut, 32'h5A5A_A5A5);
    mem_ready = 1'b0;
    mem_data  = '0;
    tick();

    // ---------------- ignored requests ----------------
    rd_start = 1'b1;
    rd_addr  = 9'h044;
    tick();                                   // REQ cycle 1
    rd_addr  = 9'h1FF;                        // rd_start still high in REQ
    tick();                                   // REQ cycle 2
    check("ign_mem_addr_req", mem_addr, 32'h044);
    check("ign_still_req",    mem_read, 1);
    mem_ready = 1'b1;
    mem_data  = 32'h0000_CAFE;
    tick();                                   // DONE, rd_start still high
    check("ign_done",          done,     1);
    check("ign_mem_addr_done", mem_addr, 32'h044);
    check("ign_dataout",       DataOut,  32'h0000_CAFE);
    mem_ready = 1'b0;
    mem_data  = '0;
    tick();                                   // DONE -> IDLE, request not queued
    rd_start = 1'b0;
    check("ign_idle_busy", busy, 0);
    tick();
    check("ign_no_second_read", mem_read, 0);
    check("ign_no_second_busy", busy,     0);
    check("ign_mem_addr_final", mem_addr, 32'h044);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
